// File: rtl/fft_inplace_ctrl_if.sv
// Stream and butterfly bundle for fft_inplace_ctrl. The slave modport is the
// FFT sequencer; the master modport is the surrounding system.
interface fft_inplace_ctrl_if #(
  parameter int LOG_N = 3
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high. A source never waits for ready before raising valid, and ready
  // never depends combinationally on valid.
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_re;
  logic [31:0]      in_im;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_re;
  logic [31:0]      out_im;
  logic             out_last;

  logic             busy;
  logic [1:0]       state;

  logic [31:0]      bf_a_re;
  logic [31:0]      bf_a_im;
  logic [31:0]      bf_b_re;
  logic [31:0]      bf_b_im;
  logic [31:0]      bf_a_o_re;
  logic [31:0]      bf_a_o_im;
  logic [31:0]      bf_b_o_re;
  logic [31:0]      bf_b_o_im;
  logic [LOG_N-2:0] tw_addr;

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    input  bf_a_o_re, bf_a_o_im, bf_b_o_re, bf_b_o_im,
    output in_ready, out_valid, out_re, out_im, out_last, busy, state,
    output bf_a_re, bf_a_im, bf_b_re, bf_b_im, tw_addr
  );

  modport master (
    output in_valid, in_re, in_im, out_ready,
    output bf_a_o_re, bf_a_o_im, bf_b_o_re, bf_b_o_im,
    input  in_ready, out_valid, out_re, out_im, out_last, busy, state,
    input  bf_a_re, bf_a_im, bf_b_re, bf_b_im, tw_addr
  );
endinterface

// File: rtl/fft_inplace_ctrl.sv
// In-place radix-2 DIF FFT sequencer: load N samples, run LOG_N*N/2 butterflies
// through an external unit, unload bins. FFT_NATURAL_ORDER_EN selects natural bin order.
module fft_inplace_ctrl #(
  parameter int LOG_N = 3
) (
  input logic               clk,
  input logic               rst,
  fft_inplace_ctrl_if.slave io
);
  localparam int N = 1 << LOG_N;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LOG_N-1:0] ld_cnt;
  logic [LOG_N-1:0] un_cnt;
  logic [LOG_N-2:0] k;
  logic [2:0]       stage;

  logic [63:0]      mem [N];

  logic [2:0]       span_log;
  logic [LOG_N-1:0] k_ext;
  logic [LOG_N-1:0] mask;
  logic [LOG_N-1:0] j;
  logic [LOG_N-1:0] a_idx;
  logic [LOG_N-1:0] b_idx;
  logic [LOG_N-1:0] rd_idx;
  logic [LOG_N-2:0] tw;
  logic [63:0]      a_word;
  logic [63:0]      b_word;
  logic [63:0]      rd_word;

  logic             in_ready;
  logic             out_valid;
  logic             out_last;
  logic             busy;
  logic             in_fire;
  logic             out_fire;
  logic             bf_en;
  logic             last_bf;

  // Butterfly addressing: a_idx is k with a zero bit inserted at position
  // log2(span); b_idx sets that bit. Twiddle index is (k mod span) << stage.
  always_comb begin
    span_log = 3'(LOG_N - 1) - stage;
    k_ext    = {1'b0, k};
    mask     = (LOG_N'(1) << span_log) - LOG_N'(1);
    j        = k_ext & mask;
    a_idx    = ((k_ext & ~mask) << 1) | j;
    b_idx    = a_idx | (LOG_N'(1) << span_log);
    tw       = j[LOG_N-2:0] << stage;
  end

`ifdef FFT_NATURAL_ORDER_EN
  always_comb begin
    rd_idx = '0;
    for (int i = 0; i < LOG_N; i++) begin
      rd_idx[i] = un_cnt[LOG_N-1-i];
    end
  end
`else
  assign rd_idx = un_cnt;
`endif

  assign a_word  = mem[a_idx];
  assign b_word  = mem[b_idx];
  assign rd_word = mem[rd_idx];

  assign last_bf = (stage == 3'(LOG_N - 1)) && (k == '1);

  // Outputs are gated by rst so the block looks idle during the reset cycle
  // regardless of the state register contents.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    bf_en     = 1'b0;
    if (!rst) begin
      case (state)
        LOAD:    in_ready = 1'b1;
        COMPUTE: begin
          busy  = 1'b1;
          bf_en = 1'b1;
        end
        UNLOAD:  begin
          busy      = 1'b1;
          out_valid = 1'b1;
        end
        default: in_ready = 1'b0;
      endcase
    end
    out_last = out_valid && (un_cnt == '1);
    in_fire  = in_ready && io.in_valid;
    out_fire = out_valid && io.out_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_fire && (ld_cnt == '1)) state_nxt = COMPUTE;
      COMPUTE: if (last_bf) state_nxt = UNLOAD;
      UNLOAD:  if (out_fire && out_last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt <= '0;
      un_cnt <= '0;
      k      <= '0;
      stage  <= '0;
    end else begin
      if (in_fire) ld_cnt <= ld_cnt + 1'b1;
      if (out_fire) un_cnt <= un_cnt + 1'b1;
      if (bf_en) begin
        if (k == '1) begin
          k     <= '0;
          stage <= last_bf ? 3'd0 : stage + 3'd1;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

  // Working buffer: not reset; results from the butterfly land unmodified.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[ld_cnt] <= {io.in_re, io.in_im};
    end else if (bf_en) begin
      mem[a_idx] <= {io.bf_a_o_re, io.bf_a_o_im};
      mem[b_idx] <= {io.bf_b_o_re, io.bf_b_o_im};
    end
  end

  always_comb begin
    io.in_ready  = in_ready;
    io.out_valid = out_valid;
    io.out_last  = out_last;
    io.busy      = busy;
    io.state     = state;
    io.out_re    = rd_word[63:32];
    io.out_im    = rd_word[31:0];
    io.bf_a_re   = a_word[63:32];
    io.bf_a_im   = a_word[31:0];
    io.bf_b_re   = b_word[63:32];
    io.bf_b_im   = b_word[31:0];
    io.tw_addr   = bf_en ? tw : '0;
  end

endmodule

// File: doc/fft_inplace_ctrl.md
# fft_inplace_ctrl

Sequencer and working buffer for a radix-2 decimation-in-frequency (DIF) FFT built around the combinational single-precision butterfly unit. It accepts N complex IEEE-754 samples over a valid/ready stream and stores them in an internal register array. It then feeds one butterfly per cycle to the external butterfly unit, computing a' = a + b and b' = (a − b)·w, and writes the results back in place. Finally it streams the N spectrum bins out.

## Interface
Parameters:
- LOG_N, 3, log2 of transform size N; legal range 3..6.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_re, in_im  in  32  input sample, IEEE-754 single.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts bin.
- out_re, out_im  out  32  output bin.
- out_last  out  1  high with bin N−1 of a frame.
- busy  out  1  high in COMPUTE or UNLOAD.
- bf_a_re, bf_a_im, bf_b_re, bf_b_im  out  32 each  butterfly operands a, b.
- bf_a_o_re, bf_a_o_im, bf_b_o_re, bf_b_o_im  in  32 each  butterfly results.
- tw_addr  out  LOG_N−1  twiddle index t. The external ROM supplies w = exp(−j2πt/N) straight to the butterfly w inputs.

## Operation
- Storage: N × 64-bit register array with asynchronous read and synchronous write. Contents are not reset.
- FSM states: LOAD → COMPUTE → UNLOAD → LOAD. rst forces LOAD and clears all counters.
- LOAD:
  - in_ready = 1.
  - On in_valid && in_ready, the sample is written to address ld_cnt and ld_cnt increments.
  - The handshake at ld_cnt = N−1 moves the FSM to COMPUTE.
- COMPUTE: stage s = 0..LOG_N−1, butterfly k = 0..N/2−1.
  - span = N >> (s+1); j = k mod span; a_idx = (k/span)·2·span + j; b_idx = a_idx + span; tw_addr = j << s.
  - bf_a and bf_b are driven combinationally from mem[a_idx] and mem[b_idx].
  - At each edge, mem[a_idx] ← bf_a_o and mem[b_idx] ← bf_b_o; k increments, wrapping to 0 with s incrementing.
  - After the last butterfly (s = LOG_N−1, k = N/2−1) the FSM moves to UNLOAD.
- UNLOAD:
  - out_valid = 1; out_re/out_im = mem[rd_idx(un_cnt)].
  - un_cnt advances on out_valid && out_ready.
  - out_last = (un_cnt == N−1). The handshake with out_last set returns the FSM to LOAD.
- No arithmetic is performed in this block; the bf_* inputs are written unmodified.

## Timing
- While rst is high and in the cycle after it: in_ready 0 during rst, then 1; out_valid 0; out_last 0; busy 0; tw_addr 0.
- bf_* outputs are undefined until a frame is loaded and are don't-care outside COMPUTE.
- Throughput: one sample per cycle in LOAD and in UNLOAD, and one butterfly per cycle in COMPUTE.
- Latency: call the cycle containing the last input handshake cycle 0.
  - Cycles 1..LOG_N·N/2 are COMPUTE.
  - out_valid first rises in cycle LOG_N·N/2 + 1. For N = 8 that is cycle 13.
- During COMPUTE, in_ready = 0 and out_valid = 0.
- out_ready is ignored outside UNLOAD, and in_valid is ignored outside LOAD.
- out_re/out_im hold steady while out_valid && !out_ready.
- Frame boundary: after the out_last handshake, in_ready is 1 in the next cycle. LOAD and UNLOAD never overlap.
- Reset mid-frame (any state): next cycle is LOAD with counters 0. The partial frame is discarded and no out_valid is produced for it.

## Configuration
- FFT_NATURAL_ORDER_EN
  - Defined: rd_idx = bit-reverse(un_cnt) over LOG_N bits, so bins emerge in natural order X[0]..X[N−1].
  - Undefined: rd_idx = un_cnt, so bins emerge in DIF bit-reversed order. For N = 8 the sequence is X[0], X[4], X[2], X[6], X[1], X[5], X[3], X[7].
  - Latency is identical in both builds.

## Test plan
- Impulse, N = 8: x[0] = 1.0 (0x3F800000), all other samples 0 → all 8 bins re = 0x3F800000, im = 0. out_last is high only on the 8th bin. Check in both configs.
- DC, N = 8: all x = 1.0 → X[0].re = 0x41000000 (8.0) and all other bins 0. With the macro undefined, the 0x41000000 bin is the first one output.
- Ordering, N = 8, x[1] = 1.0 (impulse at sample 1) → X[k] = exp(−j2πk/8). With the macro defined, bin 2 = (0, −1.0 = 0xBF800000). With the macro undefined, that same value appears at output position 2.
- Cycle count: in_valid held high, out_ready high → out_valid rises exactly 13 cycles after the last input handshake. tw_addr sequence in stage 0 is 0, 1, 2, 3.
- Backpressure: random in_valid gaps and out_ready toggling (50%) → same bins as the impulse test. Outputs stay stable while stalled.
- Reset in cycle 5 of COMPUTE → next cycle in_ready = 1, busy = 0, out_valid = 0. A following impulse frame produces the correct all-ones result.
